exec_ctrl: RTL and testbench

Execution controller for the Fibonacci processor. It gates the controller/datapath pair with a one-cycle step enable, `step_en`, and provides run, single-step, breakpoint and halt-opcode stop modes. It sits between the board clock and the controller/datapath, replacing free-running 1 Hz stepping. It also exports an instruction counter for debug display.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/sync_edge.sv | 31 +++
 rtl/exec_ctrl.sv | 140 ++++++++++++++
 tb/tb_exec_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execution controller and the
// controller/datapath it gates.
package exec_pkg;

    typedef enum logic [2:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_BRK,
        S_DONE
    } exec_state_t;

    localparam logic [1:0] MODE_HALT = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_BRK  = 2'd2;
    localparam logic [1:0] MODE_DONE = 2'd3;

    // Controller estadoAtual encodings and the stop opcode
    localparam logic [3:0] EXEC_FETCH_STATE  = 4'd0;
    localparam logic [3:0] EXEC_DECODE_STATE = 4'd1;
    localparam logic [3:0] EXEC_HALT_OPCODE  = 4'hF;

    // Externally visible mode; a single step reports as HALT
    function automatic logic [1:0] mode_of(input exec_state_t s);
        case (s)
            S_RUN:   return MODE_RUN;
            S_BRK:   return MODE_BRK;
            S_DONE:  return MODE_DONE;
            default: return MODE_HALT;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a rising-edge
// strobe derived from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise
);

    logic ff1;
    logic ff2;
    logic prev;

    // Synchronizer chain and previous-level register for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            ff1  <= 1'b0;
            ff2  <= 1'b0;
            prev <= 1'b0;
        end else begin
            ff1  <= sig;
            ff2  <= ff1;
            prev <= ff2;
        end
    end

    assign level = ff2;
    assign rise  = ff2 & ~prev;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: issues one-cycle step strobes to the controller/
// datapath in run, single-step, breakpoint and halt-opcode stop modes, and
// counts fetched instructions for debug display.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned CNT_W        = 16,
    parameter logic [3:0]  HALT_OPCODE  = EXEC_HALT_OPCODE,
    parameter logic [3:0]  FETCH_STATE  = EXEC_FETCH_STATE,
    parameter logic [3:0]  DECODE_STATE = EXEC_DECODE_STATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             brk_en,
    input  logic [3:0]       brk_opcode,
    input  logic [3:0]       opcode,
    input  logic [3:0]       estado,
    output logic             step_en,
    output logic [1:0]       mode,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic             tick_led
);

    localparam int unsigned    TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    exec_state_t   state;
    exec_state_t   state_next;
    logic          step_en_next;
    logic          run_step;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          run_sync;
    logic          run_rise_unused;
    logic          step_edge;
    logic          step_level_unused;

    sync_edge u_run_sync (
        .clk   (clk),
        .rst   (rst),
        .sig   (run_sw),
        .level (run_sync),
        .rise  (run_rise_unused)
    );

    sync_edge u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .sig   (step_btn),
        .level (step_level_unused),
        .rise  (step_edge)
    );

    assign tick = (state == S_RUN) && (tick_cnt == TICK_LAST);

    // Next state and step strobe; stop detection overrides run/step flow
    always_comb begin
        state_next   = state;
        step_en_next = 1'b0;
        run_step     = 1'b0;
        case (state)
            S_HALT: begin
                if (run_sync) begin
                    state_next = S_RUN;
                end else if (step_edge) begin
                    state_next   = S_STEP;
                    step_en_next = 1'b1;
                end
            end
            S_RUN: begin
                if (!run_sync) begin
                    state_next = S_HALT;
                end else if (tick) begin
                    step_en_next = 1'b1;
                    run_step     = 1'b1;
                end
            end
            S_STEP: state_next = S_HALT;
            S_BRK: begin
                if (!run_sync) begin
                    state_next = S_HALT;
                end else if (step_edge) begin
                    state_next   = S_STEP;
                    step_en_next = 1'b1;
                end
            end
            S_DONE: state_next = S_DONE;
            default: state_next = S_HALT;
        endcase
        if (step_en && (estado == DECODE_STATE) &&
            (state == S_RUN || state == S_STEP)) begin
            if (opcode == HALT_OPCODE) begin
                state_next   = S_DONE;
                step_en_next = 1'b0;
                run_step     = 1'b0;
            end else if (brk_en && (opcode == brk_opcode) && (state == S_RUN)) begin
                state_next   = S_BRK;
                step_en_next = 1'b0;
                run_step     = 1'b0;
            end
        end
    end

    // State, strobe, tick divider, LED and saturating instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_HALT;
            step_en     <= 1'b0;
            tick_cnt    <= '0;
            tick_led    <= 1'b0;
            instr_count <= '0;
        end else begin
            state   <= state_next;
            step_en <= step_en_next;
            // Divider only runs while staying in RUN; any exit clears it
            if (state == S_RUN && state_next == S_RUN) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end else begin
                tick_cnt <= '0;
            end
            if (run_step) begin
                tick_led <= ~tick_led;
            end
            if (step_en && (estado == FETCH_STATE) && (instr_count != '1)) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    // Mode and halted flags decoded from the state
    always_comb begin
        mode   = mode_of(state);
        halted = (state != S_RUN);
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl with a short tick divider and a narrow counter.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_sw;
    logic       step_btn;
    logic       brk_en;
    logic [3:0] brk_opcode;
    logic [3:0] opcode;
    logic [3:0] estado;
    logic       step_en;
    logic [1:0] mode;
    logic       halted;
    logic [3:0] instr_count;
    logic       tick_led;

    always #5 clk = ~clk;

    exec_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .brk_en      (brk_en),
        .brk_opcode  (brk_opcode),
        .opcode      (opcode),
        .estado      (estado),
        .step_en     (step_en),
        .mode        (mode),
        .halted      (halted),
        .instr_count (instr_count),
        .tick_led    (tick_led)
    );

    typedef struct {
        logic       rst;
        logic       run_sw;
        logic [3:0] estado;
        logic       exp_se;
        logic [1:0] exp_mode;
        logic [3:0] exp_cnt;
        logic       exp_led;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   pulses = 0;

    function automatic vec_t mk(input logic r, input logic rs, input logic [3:0] es,
                                input logic se, input logic [1:0] md,
                                input logic [3:0] cn, input logic ld);
        vec_t v;
        v.rst = r; v.run_sw = rs; v.estado = es;
        v.exp_se = se; v.exp_mode = md; v.exp_cnt = cn; v.exp_led = ld;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (step_en === 1'b1) pulses++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset(input logic run);
        rst = 1'b0; run_sw = run; step_btn = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
    endtask

    task automatic wait_step(input int max, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            cyc();
            if (step_en === 1'b1) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t e;
        logic exp_halted;

        rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0; brk_en = 1'b0;
        brk_opcode = 4'h0; opcode = 4'h0; estado = 4'h0;

        // reset hold with run_sw high, then RUN with estado cycling per step
        //              rst  run es  se md cnt led
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2, 1, 1, 1, 1));
        vecs.push_back(mk(1, 1, 2, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 3, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 3, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 3, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 3, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 2, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 2, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; run_sw = vecs[i].run_sw; estado = vecs[i].estado;
            sb.push_back(vecs[i]);
            cyc();
            e = sb.pop_front();
            exp_halted = (e.exp_mode != 2'd1);
            n_vec++;
            if (step_en !== e.exp_se || mode !== e.exp_mode || instr_count !== e.exp_cnt ||
                tick_led !== e.exp_led || halted !== exp_halted) begin
                n_bad++;
                $display("FAIL vec%0d: got se=%0b mode=%0d cnt=%0d led=%0b halted=%0b, expected se=%0b mode=%0d cnt=%0d led=%0b halted=%0b",
                         i, step_en, mode, instr_count, tick_led, halted,
                         e.exp_se, e.exp_mode, e.exp_cnt, e.exp_led, exp_halted);
            end
        end

        // single step from HALT: three-edge latency, one pulse per press
        estado = 4'd0; opcode = 4'h0; brk_en = 1'b0;
        do_reset(1'b0);
        step_btn = 1'b1; pulses = 0;
        cyc(); cyc();
        chk("step_lat_e2", step_en, 0);
        cyc();
        chk("step_lat_e3", step_en, 1);
        chk("step_mode", mode, 0);
        cyc();
        chk("step_one_cycle", step_en, 0);
        repeat (6) cyc();
        chk("step_pulses", pulses, 1);
        chk("step_mode_back", mode, 0);
        chk("step_count", instr_count, 1);
        step_btn = 1'b0;
        repeat (3) cyc();
        step_btn = 1'b1; pulses = 0;
        repeat (6) cyc();
        chk("step_second", pulses, 1);
        chk("step_count2", instr_count, 2);
        step_btn = 1'b0;

        // breakpoint in RUN, then step past it on the same opcode
        brk_en = 1'b1; brk_opcode = 4'h3; opcode = 4'h3; estado = 4'd1;
        do_reset(1'b1);
        wait_step(20, "brk_first_step");
        cyc();
        chk("brk_mode", mode, 2);
        chk("brk_halted", halted, 1);
        pulses = 0;
        repeat (12) cyc();
        chk("brk_no_step", pulses, 0);
        step_btn = 1'b1; pulses = 0;
        cyc();
        run_sw = 1'b0;
        cyc();
        chk("brk_mode_hold", mode, 2);
        cyc();
        chk("brk_step_en", step_en, 1);
        chk("brk_step_mode", mode, 0);
        cyc();
        chk("brk_after_step", mode, 0);
        repeat (8) cyc();
        chk("brk_step_pulses", pulses, 1);
        chk("brk_not_reentered", mode, 0);
        step_btn = 1'b0;

        // halt opcode beats breakpoint; DONE ignores everything but reset
        brk_en = 1'b1; brk_opcode = 4'hF; opcode = 4'hF; estado = 4'd1;
        do_reset(1'b1);
        wait_step(20, "done_first_step");
        cyc();
        chk("done_mode", mode, 3);
        pulses = 0;
        run_sw = 1'b0; repeat (4) cyc();
        run_sw = 1'b1; repeat (4) cyc();
        step_btn = 1'b1; repeat (5) cyc();
        step_btn = 1'b0; repeat (3) cyc();
        chk("done_no_step", pulses, 0);
        chk("done_sticky", mode, 3);
        rst = 1'b0;
        cyc();
        chk("done_reset_mode", mode, 0);
        chk("done_reset_se", step_en, 0);
        rst = 1'b1;

        // halt opcode reached by a single step
        brk_en = 1'b0;
        do_reset(1'b0);
        step_btn = 1'b1;
        repeat (4) cyc();
        chk("step_to_done", mode, 3);
        step_btn = 1'b0;

        // saturating instruction counter
        brk_en = 1'b0; opcode = 4'h0; estado = 4'd0;
        do_reset(1'b1);
        pulses = 0;
        repeat (100) cyc();
        chk("sat_count", instr_count, 15);
        chk("run_pulses", pulses, 24);

        // run switch drops in the same cycle as a tick
        do_reset(1'b1);
        pulses = 0;
        repeat (4) cyc();
        run_sw = 1'b0;
        cyc(); cyc();
        chk("fall_mode_before", mode, 1);
        cyc();
        chk("fall_no_step", step_en, 0);
        chk("fall_mode", mode, 0);
        repeat (6) cyc();
        chk("fall_pulses", pulses, 0);
        chk("fall_led", tick_led, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
